row_uram_arbiter: RTL
=====================

ROW_URAM_ARBITER -- requirements
Module: row_uram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8: number of cores per row sharing one URAM port.
REQ-002 SHALL have parameter ADDR_W, default 12: URAM word-address width.
REQ-003 SHALL have parameter FLUSH_THRESHOLD, default 4096: URAM word writes that trigger a flush.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: idle-owner watchdog limit; used only with the watchdog macro.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_core_req, input, NUM_CORES: per-core access request.
REQ-008 SHALL have port i_core_locked, input, NUM_CORES: per-core hold-grant indication.
REQ-009 SHALL have port o_core_grant, output, NUM_CORES: registered grant; one-hot or zero.
REQ-010 SHALL have port o_uram_emptied, output, 1: registered one-cycle pulse, broadcast to all cores.
REQ-011 SHALL have ports i_core_uram_en (NUM_CORES), i_core_uram_wr_en (NUM_CORES), i_core_uram_addr (NUM_CORES*ADDR_W) and i_core_uram_wr_data (NUM_CORES*32), all inputs: per-core URAM buses; core k occupies slice k.
REQ-012 SHALL have ports o_uram_en (1), o_uram_wr_en (1), o_uram_addr (ADDR_W) and o_uram_wr_data (32), all outputs: registered URAM port.
REQ-013 SHALL have port o_flush_req, output, 1: asks the host to drain the URAM.
REQ-014 SHALL have port i_drain_done, input, 1: one-cycle host pulse that drain is complete.

Function
REQ-015 SHALL implement an FSM with states IDLE, GRANT and FLUSH.
REQ-016 IDLE: if any i_core_req is set, SHALL pick the first requester at or after rr_ptr (wrapping modulo NUM_CORES), record it as owner, assert its grant bit on the next edge and enter GRANT.
REQ-017 Grant latency SHALL be exactly 1 cycle from a req sampled in IDLE to o_core_grant visible.
REQ-018 GRANT: owner SHALL keep the grant while i_core_req[owner] or i_core_locked[owner] is 1; requests from other cores SHALL be ignored.
REQ-019 GRANT release: when both owner bits are 0, SHALL clear the grant and set rr_ptr = (owner+1) mod NUM_CORES on the next edge.
REQ-020 On release, SHALL go to FLUSH if wr_count >= FLUSH_THRESHOLD, else to IDLE.
REQ-021 SHALL never grant in the release cycle: a new grant needs at least one cycle in IDLE.
REQ-022 URAM mux: each edge SHALL register the owner's en/wr_en/addr/wr_data to the o_uram_* ports while in GRANT; otherwise o_uram_en=0, o_uram_wr_en=0, addr=0, data=0.
REQ-023 Mux latency SHALL be 1 cycle.
REQ-024 wr_count (width clog2(FLUSH_THRESHOLD+1)) SHALL increment when the registered o_uram_en and o_uram_wr_en are both 1.
REQ-025 wr_count SHALL saturate at FLUSH_THRESHOLD.
REQ-026 A flush SHALL never preempt the current owner; it is taken only at release.
REQ-027 FLUSH: o_flush_req SHALL be 1 and no grants SHALL be issued.
REQ-028 On i_drain_done in FLUSH, SHALL on the next edge clear wr_count, deassert o_flush_req, pulse o_uram_emptied for 1 cycle and enter IDLE.
REQ-029 i_drain_done outside FLUSH SHALL be ignored.
REQ-030 Simultaneous req and locked: locked alone with no prior grant SHALL NOT create a grant; only req does.

Reset
REQ-031 Reset SHALL force state=IDLE, owner=0, rr_ptr=0 and wr_count=0.
REQ-032 Reset SHALL force o_core_grant=0, o_uram_en=0, o_uram_wr_en=0, o_uram_addr=0, o_uram_wr_data=0, o_flush_req=0 and o_uram_emptied=0.
REQ-033 Reset asserted mid-GRANT or mid-FLUSH SHALL take effect immediately (asynchronously) and abort the transaction with no emptied pulse.

Configuration
REQ-034 With macro ROW_ARB_WATCHDOG_EN defined, SHALL count consecutive GRANT cycles with i_core_uram_en[owner]=0 and reset the count on any owner access.
REQ-035 With ROW_ARB_WATCHDOG_EN defined, when the count reaches TIMEOUT_CYCLES, SHALL force release as in REQ-019 regardless of req/locked.
REQ-036 Without ROW_ARB_WATCHDOG_EN, SHALL contain no watchdog logic; the grant is held indefinitely.

Verification
REQ-037 Reset; i_core_req=8'b0000_0100 -> o_core_grant=8'b0000_0100 one cycle later; o_uram_* all 0 during reset.
REQ-038 Cores 1 and 6 request together, each releasing after 3 cycles -> grant order 1, 6, 1; rr_ptr=2 after the first release.
REQ-039 Core 3 granted writes addr 0x0A5, data 0xDEADBEEF, wr_en=1 -> o_uram_addr=0x0A5, o_uram_wr_data=0xDEADBEEF, o_uram_wr_en=1 one cycle later; core 5 bus activity never appears.
REQ-040 FLUSH_THRESHOLD=4; owner writes 6 words then releases -> o_flush_req=1 and pending req on core 0 not granted; i_drain_done pulse -> o_uram_emptied one-cycle pulse, then grant to core 0.
REQ-041 ROW_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16: owner holds locked=1 with no uram_en -> grant drops after 16 cycles; without the macro, grant still held at 1000 cycles.
REQ-042 Assert reset during FLUSH -> o_flush_req=0 immediately; wr_count=0; no o_uram_emptied pulse.

Source files
------------

// File: rtl/row_uram_arbiter.sv
// Round-robin arbiter handing one core per row ownership of a shared URAM port, with a
// write-count flush handshake. Optional idle-owner watchdog: define ROW_ARB_WATCHDOG_EN.

module row_uram_lane #(
    parameter int ADDR_W = 12
) (
    input  logic              sel,
    input  logic              en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [ADDR_W+33:0] bus
);
    // Zero when not selected so the top can OR-reduce all lanes.
    assign bus = sel ? {en, wr_en, addr, wr_data} : '0;
endmodule

module row_uram_arbiter #(
    parameter int NUM_CORES       = 8,
    parameter int ADDR_W          = 12,
    parameter int FLUSH_THRESHOLD = 4096,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        i_core_req,
    input  logic [NUM_CORES-1:0]        i_core_locked,
    output logic [NUM_CORES-1:0]        o_core_grant,
    output logic                        o_uram_emptied,
    input  logic [NUM_CORES-1:0]        i_core_uram_en,
    input  logic [NUM_CORES-1:0]        i_core_uram_wr_en,
    input  logic [NUM_CORES*ADDR_W-1:0] i_core_uram_addr,
    input  logic [NUM_CORES*32-1:0]     i_core_uram_wr_data,
    output logic                        o_uram_en,
    output logic                        o_uram_wr_en,
    output logic [ADDR_W-1:0]           o_uram_addr,
    output logic [31:0]                 o_uram_wr_data,
    output logic                        o_flush_req,
    input  logic                        i_drain_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(FLUSH_THRESHOLD + 1);
    localparam int BUS_W = ADDR_W + 34;

    localparam logic [IDX_W:0]   NC_EXT = (IDX_W+1)'(NUM_CORES);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0] TH     = CNT_W'(FLUSH_THRESHOLD);

    logic [1:0]                        state;
    logic [IDX_W-1:0]                  owner;
    logic [IDX_W-1:0]                  rr_ptr;
    logic [IDX_W-1:0]                  owner_nxt;
    logic [IDX_W-1:0]                  pick_idx;
    logic                              pick_valid;
    logic [IDX_W:0]                    rr_sum;
    logic                              hold;
    logic                              wd_expire;
    logic [CNT_W-1:0]                  wr_count;
    logic [NUM_CORES-1:0][BUS_W-1:0]   lane_bus;
    logic [BUS_W-1:0]                  mux_bus;

    // Walk offsets high to low so the nearest requester at/after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            rr_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (rr_sum >= NC_EXT)
                rr_sum = rr_sum - NC_EXT;
            if (i_core_req[rr_sum[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_sum[IDX_W-1:0];
            end
        end
    end

    assign owner_nxt = (owner == LAST) ? '0 : owner + IDX_W'(1);
    assign hold      = (i_core_req[owner] | i_core_locked[owner]) & ~wd_expire;

`ifdef ROW_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive granted cycle without an owner access.
    assign wd_expire = (state == GRANT) && !i_core_uram_en[owner] && (idle_cnt == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (state != GRANT || i_core_uram_en[owner] || wd_expire)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + WD_W'(1);
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_expire      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= '0;
            rr_ptr         <= '0;
            o_core_grant   <= '0;
            o_flush_req    <= 1'b0;
            o_uram_emptied <= 1'b0;
        end else begin
            o_uram_emptied <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner        <= pick_idx;
                        o_core_grant <= NUM_CORES'(1) << pick_idx;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    // Flush is only considered here, so an owner is never preempted.
                    if (!hold) begin
                        o_core_grant <= '0;
                        rr_ptr       <= owner_nxt;
                        if (wr_count >= TH) begin
                            state       <= FLUSH;
                            o_flush_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (i_drain_done) begin
                        o_flush_req    <= 1'b0;
                        o_uram_emptied <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wr_count <= '0;
        else if (state == FLUSH && i_drain_done)
            wr_count <= '0;
        else if (o_uram_en && o_uram_wr_en && wr_count != TH)
            wr_count <= wr_count + CNT_W'(1);
    end

    // The grant vector is the owner one-hot in GRANT and zero elsewhere, so it doubles as mux select.
    for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
        row_uram_lane #(.ADDR_W(ADDR_W)) u_lane (
            .sel     (o_core_grant[k]),
            .en      (i_core_uram_en[k]),
            .wr_en   (i_core_uram_wr_en[k]),
            .addr    (i_core_uram_addr[k*ADDR_W +: ADDR_W]),
            .wr_data (i_core_uram_wr_data[k*32 +: 32]),
            .bus     (lane_bus[k])
        );
    end

    always_comb begin
        mux_bus = '0;
        for (int k = 0; k < NUM_CORES; k++)
            mux_bus = mux_bus | lane_bus[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_uram_en      <= 1'b0;
            o_uram_wr_en   <= 1'b0;
            o_uram_addr    <= '0;
            o_uram_wr_data <= '0;
        end else begin
            {o_uram_en, o_uram_wr_en, o_uram_addr, o_uram_wr_data} <= mux_bus;
        end
    end

endmodule
